mem_request_unit: RTL and testbench
===================================

// Module: mem_request_unit
// PURPOSE
//  Consumer side of the EX/MEM latch: turns the latch's dMemREN/dMemWEN/address/store-data
//  into a registered dcache request and returns the writeEN/flush pair that holds or
//  advances the EX/MEM latch until the access finishes.
//  Captures load data for MEM/WB, latches halt and counts memory-stall cycles.
// PARAMETERS
//  WORD_W    32    data/address width
//  CNT_W     32    width of stall-cycle counter
//  TIMEOUT   1024  max BUSY cycles before mem_err is set; 0 disables the check
// PORTS
//  CLK            in   1       clock, rising edge
//  nRST           in   1       asynchronous active-low reset
//  em_dMemREN     in   1       EX/MEM dMemREN_out
//  em_dMemWEN     in   1       EX/MEM dMemWEN_out
//  em_addr        in   WORD_W  EX/MEM aluOutport_out
//  em_store       in   WORD_W  EX/MEM rdat2_out
//  em_halt        in   1       EX/MEM Halt_out
//  flush_req      in   1       branch/jump flush request from hazard logic
//  dhit           in   1       dcache done, valid for one cycle
//  dmemload       in   WORD_W  dcache read data, valid with dhit
//  dmemREN        out  1       registered dcache read request
//  dmemWEN        out  1       registered dcache write request
//  dmemaddr       out  WORD_W  registered request address
//  dmemstore      out  WORD_W  registered store data
//  ld_data        out  WORD_W  captured load word, to MEM/WB
//  em_writeEN     out  1       EX/MEM latch enable; 0 = hold
//  em_flush       out  1       EX/MEM latch flush
//  halt           out  1       sticky halt
//  mem_err        out  1       sticky timeout flag
//  stall_cnt      out  CNT_W   memory-stall cycles since reset
// BEHAVIOUR
//  Reset
//  - All registered outputs are 0. State is IDLE.
//  FSM IDLE/BUSY/DONE
//  - IDLE: if REN|WEN, register address/store data and assert REN or WEN (REN wins if
//    both are set). Next state is BUSY. Otherwise stay in IDLE.
//  - BUSY: requests stay asserted and stable until dhit.
//  - On dhit: drop requests next edge, capture dmemload into ld_data (reads only),
//    next state is DONE.
//  - DONE: one cycle, no request. Next state is IDLE.
//  - Minimum latency: request at edge 1, dhit at edge 2, em_writeEN=1 in the DONE cycle.
//  em_writeEN (combinational)
//  - 1 when (IDLE && !REN && !WEN) or DONE.
//  - 0 otherwise: IDLE with a pending op, or BUSY.
//  - So the latch holds exactly while a memory op is outstanding.
//  em_flush (combinational)
//  - flush_req && !(BUSY).
//  - A flush arriving in BUSY is remembered in a pending bit and issued in DONE.
//  - An issued dcache transaction is never aborted.
//  - Flush in IDLE with a pending op: flush wins, no request is issued, state stays IDLE.
//  ld_data
//  - Holds its value until the next read dhit. It is not changed by a write.
//  halt
//  - Set when em_halt && em_writeEN. Cleared only by reset.
//  - Once set, IDLE issues no new requests.
//  - A BUSY transaction in progress still completes.
//  stall_cnt
//  - +1 each cycle em_writeEN==0 && !halt.
//  - Saturates at all-ones and does not wrap.
//  TIMEOUT
//  - wait counter clears on entry to BUSY and counts BUSY cycles.
//  - When it reaches TIMEOUT, mem_err is set (sticky).
//  - State stays in BUSY; no recovery without reset.
//  dhit outside BUSY is ignored.
//  nRST low mid-transaction
//  - Immediate return to IDLE with outputs 0, including the pending flush bit.
// STRUCTURE
//  Package cpu_types_pkg
//  - memreq_state_t enum {IDLE, BUSY, DONE}; word_t is already defined there.
//  Sub-module sat_counter
//  - Parameterised width, enable and saturate. Used for stall_cnt and the wait counter.
//  Everything else lives in one always_ff plus one always_comb.
// TESTING
//  1. Reset then no ops: em_writeEN=1, dmemREN=0, dmemWEN=0, stall_cnt=0, ld_data=0.
//  2. Load, addr=0x100, dhit 3 cycles later with dmemload=0xDEADBEEF
//     -> dmemREN high 3 cycles, em_writeEN=0 for 4 cycles then 1 in DONE,
//        ld_data=0xDEADBEEF, stall_cnt=4.
//  3. Store, addr=0x204, data=0x12345678, dhit after 1 cycle
//     -> dmemWEN=1, dmemaddr=0x204, dmemstore=0x12345678 stable until dhit,
//        ld_data unchanged.
//  4. flush_req during BUSY
//     -> em_flush=0 until dhit, em_flush=1 in the DONE cycle, dmemREN not re-issued after.
//  5. TIMEOUT=8 with no dhit -> mem_err=1 on cycle 8 of BUSY, dmemREN still 1;
//     nRST low -> all outputs 0.
//  6. Halt advanced through an idle latch -> halt=1, then em_dMemREN=1 issues no request
//     and stall_cnt stays frozen.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU word type and memory-request FSM state encoding
package cpu_types_pkg;
  localparam int WORD_BITS = 32;
  typedef logic [WORD_BITS-1:0] word_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} memreq_state_t;
endpackage

// File: rtl/mem_request_unit_sat_counter.sv
// sat_counter: saturating up-counter with clear and enable
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : synchronous clear, wins over enable
//   i_en           : count enable, holds at all-ones
//   o_q            : count value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_q
);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_q <= '0;
    else if (i_clr) o_q <= '0;
    else if (i_en && !(&o_q)) o_q <= o_q + 1'b1;
endmodule

// File: rtl/mem_request_unit.sv
// mem_request_unit: registers EX/MEM memory ops into dcache requests and holds the latch until done
//   CLK, nRST               : clock, async active-low reset
//   em_dMemREN/WEN/addr/store/halt : EX/MEM latch outputs
//   flush_req               : branch/jump flush request
//   dhit, dmemload          : dcache completion and read data
//   dmemREN/WEN/addr/store  : registered dcache request
//   ld_data                 : captured load word for MEM/WB
//   em_writeEN, em_flush    : EX/MEM latch control
//   halt, mem_err           : sticky halt and timeout flags
//   stall_cnt               : saturating count of memory-stall cycles
module mem_request_unit
  import cpu_types_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              em_dMemREN,
  input  logic              em_dMemWEN,
  input  logic [WORD_W-1:0] em_addr,
  input  logic [WORD_W-1:0] em_store,
  input  logic              em_halt,
  input  logic              flush_req,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic [WORD_W-1:0] ld_data,
  output logic              em_writeEN,
  output logic              em_flush,
  output logic              halt,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt
);
  localparam int WAIT_W = $clog2(TIMEOUT + 2);
  memreq_state_t r_state, w_next;
  logic r_fpend, r_halt, r_err, w_op, w_issue;
  logic [WAIT_W-1:0] w_wait;
  assign halt    = r_halt;
  assign mem_err = r_err;
  // a flush in IDLE suppresses the pending op; after halt nothing new is issued
  always_comb begin
    w_op       = em_dMemREN | em_dMemWEN;
    w_issue    = r_state == IDLE && w_op && !r_halt && !flush_req;
    em_writeEN = (r_state == IDLE && !w_op) || r_state == DONE;
    em_flush   = (flush_req && r_state != BUSY) || (r_state == DONE && r_fpend);
    w_next     = w_issue ? BUSY : r_state == BUSY ? (dhit ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      r_state   <= IDLE;
      r_fpend   <= 1'b0;
      r_halt    <= 1'b0;
      r_err     <= 1'b0;
      dmemREN   <= 1'b0;
      dmemWEN   <= 1'b0;
      dmemaddr  <= '0;
      dmemstore <= '0;
      ld_data   <= '0;
    end else begin
      r_state <= w_next;
      r_fpend <= r_state == BUSY && (r_fpend || flush_req);
      r_halt  <= r_halt || (em_halt && em_writeEN);
      r_err   <= r_err || (TIMEOUT != 0 && r_state == BUSY && int'(w_wait) + 1 == TIMEOUT);
      if (w_issue) begin
        dmemREN   <= em_dMemREN;
        dmemWEN   <= !em_dMemREN;
        dmemaddr  <= em_addr;
        dmemstore <= em_store;
      end else if (r_state == BUSY && dhit) begin
        dmemREN <= 1'b0;
        dmemWEN <= 1'b0;
        if (dmemREN) ld_data <= dmemload;
      end
    end
  sat_counter #(.W(CNT_W)) u_stall (
    .i_clk(CLK), .i_rst_n(nRST), .i_clr(1'b0),
    .i_en(!em_writeEN && !r_halt), .o_q(stall_cnt)
  );
  sat_counter #(.W(WAIT_W)) u_wait (
    .i_clk(CLK), .i_rst_n(nRST), .i_clr(w_issue),
    .i_en(r_state == BUSY), .o_q(w_wait)
  );
endmodule

// File: tb/tb_mem_request_unit.sv
// tb_mem_request_unit: table-driven cycle vectors plus timeout, reset and halt sequences
module tb_mem_request_unit;
  logic CLK = 1'b0, nRST = 1'b0;
  logic em_dMemREN = 0, em_dMemWEN = 0, em_halt = 0, flush_req = 0, dhit = 0;
  logic [31:0] em_addr = 0, em_store = 0, dmemload = 0;
  logic dmemREN, dmemWEN, em_writeEN, em_flush, halt, mem_err;
  logic [31:0] dmemaddr, dmemstore, ld_data, stall_cnt;
  int n_cmp = 0, n_err = 0;

  mem_request_unit #(.WORD_W(32), .CNT_W(32), .TIMEOUT(8)) dut (
    .CLK(CLK), .nRST(nRST), .em_dMemREN(em_dMemREN), .em_dMemWEN(em_dMemWEN),
    .em_addr(em_addr), .em_store(em_store), .em_halt(em_halt), .flush_req(flush_req),
    .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .ld_data(ld_data),
    .em_writeEN(em_writeEN), .em_flush(em_flush), .halt(halt), .mem_err(mem_err),
    .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] ren, wen, fl, dh, addr, store, load;
    logic [31:0] e_ren, e_wen, e_we, e_fl, e_addr, e_store, e_ld, e_stall;
  } vec_t;
  vec_t v [25];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // ren wen fl dh addr store load | ren wen we fl addr store ld stall
    v = '{
      '{0,0,0,0,0,0,0,                          0,0,1,0,0,0,0,0},
      '{0,0,0,0,0,0,0,                          0,0,1,0,0,0,0,0},
      '{1,0,0,0,'h100,0,0,                      0,0,0,0,0,0,0,0},
      '{1,0,0,0,'h100,0,0,                      1,0,0,0,'h100,0,0,1},
      '{1,0,0,0,'h100,0,0,                      1,0,0,0,'h100,0,0,2},
      '{1,0,0,1,'h100,0,'hDEADBEEF,             1,0,0,0,'h100,0,0,3},
      '{1,0,0,0,'h100,0,0,                      0,0,1,0,'h100,0,'hDEADBEEF,4},
      '{0,1,0,0,'h204,'h12345678,0,             0,0,0,0,'h100,0,'hDEADBEEF,4},
      '{0,1,0,0,'h204,'h12345678,0,             0,1,0,0,'h204,'h12345678,'hDEADBEEF,5},
      '{0,1,0,1,'h204,'h12345678,'hFFFFFFFF,    0,1,0,0,'h204,'h12345678,'hDEADBEEF,6},
      '{0,1,0,0,'h204,'h12345678,0,             0,0,1,0,'h204,'h12345678,'hDEADBEEF,7},
      '{1,0,0,0,'h300,0,0,                      0,0,0,0,'h204,'h12345678,'hDEADBEEF,7},
      '{1,0,1,0,'h300,0,0,                      1,0,0,0,'h300,0,'hDEADBEEF,8},
      '{1,0,0,1,'h300,0,'hCAFEF00D,             1,0,0,0,'h300,0,'hDEADBEEF,9},
      '{1,0,0,0,'h300,0,0,                      0,0,1,1,'h300,0,'hCAFEF00D,10},
      '{0,0,0,0,0,0,0,                          0,0,1,0,'h300,0,'hCAFEF00D,10},
      '{0,0,0,0,0,0,0,                          0,0,1,0,'h300,0,'hCAFEF00D,10},
      '{1,0,1,0,'h400,'h99,0,                   0,0,0,1,'h300,0,'hCAFEF00D,10},
      '{0,0,0,0,0,0,0,                          0,0,1,0,'h300,0,'hCAFEF00D,11},
      '{0,0,0,1,0,0,'h11111111,                 0,0,1,0,'h300,0,'hCAFEF00D,11},
      '{0,0,0,0,0,0,0,                          0,0,1,0,'h300,0,'hCAFEF00D,11},
      '{1,1,0,0,'h500,'h77,0,                   0,0,0,0,'h300,0,'hCAFEF00D,11},
      '{1,1,0,1,'h500,'h77,'hA5A5A5A5,          1,0,0,0,'h500,'h77,'hCAFEF00D,12},
      '{1,1,0,0,'h500,'h77,0,                   0,0,1,0,'h500,'h77,'hA5A5A5A5,13},
      '{0,0,0,0,0,0,0,                          0,0,1,0,'h500,'h77,'hA5A5A5A5,13}
    };
    #12 nRST = 1'b1;
    tick();
    for (int i = 0; i < 25; i++) begin
      em_dMemREN = v[i].ren[0]; em_dMemWEN = v[i].wen[0];
      flush_req = v[i].fl[0]; dhit = v[i].dh[0];
      em_addr = v[i].addr; em_store = v[i].store; dmemload = v[i].load;
      #2;
      chk($sformatf("r%0d dmemREN", i), 32'(dmemREN), v[i].e_ren);
      chk($sformatf("r%0d dmemWEN", i), 32'(dmemWEN), v[i].e_wen);
      chk($sformatf("r%0d em_writeEN", i), 32'(em_writeEN), v[i].e_we);
      chk($sformatf("r%0d em_flush", i), 32'(em_flush), v[i].e_fl);
      chk($sformatf("r%0d dmemaddr", i), dmemaddr, v[i].e_addr);
      chk($sformatf("r%0d dmemstore", i), dmemstore, v[i].e_store);
      chk($sformatf("r%0d ld_data", i), ld_data, v[i].e_ld);
      chk($sformatf("r%0d stall_cnt", i), stall_cnt, v[i].e_stall);
      tick();
    end
    em_dMemREN = 1; em_dMemWEN = 0; flush_req = 0; dhit = 0; em_addr = 'h600; em_store = 0;
    tick();
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 7) chk("timeout err before 8", 32'(mem_err), 0);
      if (k == 8) chk("timeout err at 8", 32'(mem_err), 1);
      if (k == 8) chk("timeout ren held", 32'(dmemREN), 1);
      if (k == 9) chk("timeout stays busy", 32'(em_writeEN), 0);
    end
    em_dMemREN = 0;
    #3 nRST = 1'b0;
    #1;
    chk("rst dmemREN", 32'(dmemREN), 0);
    chk("rst dmemaddr", dmemaddr, 0);
    chk("rst ld_data", ld_data, 0);
    chk("rst mem_err", 32'(mem_err), 0);
    chk("rst stall_cnt", stall_cnt, 0);
    chk("rst em_writeEN", 32'(em_writeEN), 1);
    tick();
    nRST = 1'b1;
    tick();
    chk("post-rst mem_err", 32'(mem_err), 0);
    chk("post-rst halt", 32'(halt), 0);
    em_halt = 1;
    tick();
    em_halt = 0;
    chk("halt set", 32'(halt), 1);
    em_dMemREN = 1; em_addr = 'h700;
    #1;
    chk("halt hold latch", 32'(em_writeEN), 0);
    for (int k = 0; k < 3; k++) tick();
    chk("halt no request", 32'(dmemREN), 0);
    chk("halt addr unchanged", dmemaddr, 0);
    chk("halt stall frozen", stall_cnt, 0);
    chk("halt sticky", 32'(halt), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
